// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, register array with bypassed dual read ports, retirement counters
module wb_regfile #(
  parameter int WORD_LEN          = 32,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int CNT_LEN           = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN,
  input  logic                         MEM_R_EN,
  input  logic [WORD_LEN-1:0]          ALURes,
  input  logic [WORD_LEN-1:0]          memReadVal,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2,
  input  logic                         clrCnt,
  output logic [WORD_LEN-1:0]          WB_Value,
  output logic [WORD_LEN-1:0]          reg1,
  output logic [WORD_LEN-1:0]          reg2,
  output logic [CNT_LEN-1:0]           retireCnt,
  output logic [CNT_LEN-1:0]           loadCnt
);
  localparam int DEPTH = 1 << REG_FILE_ADDR_LEN;
  logic [WORD_LEN-1:0] r_regs [DEPTH];
  logic [CNT_LEN-1:0]  r_ret;
  logic [CNT_LEN-1:0]  r_ld;
  logic                w_wr;
  assign WB_Value = MEM_R_EN ? memReadVal : ALURes;
  assign w_wr     = WB_EN && (dest != '0);
  // gating on rst keeps the bypass from leaking WB_Value while in reset
  assign reg1 = (!rst || src1 == '0) ? '0 : (WB_EN && dest == src1) ? WB_Value : r_regs[src1];
  assign reg2 = (!rst || src2 == '0) ? '0 : (WB_EN && dest == src2) ? WB_Value : r_regs[src2];
  assign retireCnt = r_ret;
  assign loadCnt   = r_ld;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    else if (w_wr)
      r_regs[dest] <= WB_Value;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ret <= '0;
      r_ld  <= '0;
    end else if (clrCnt) begin
      r_ret <= '0;
      r_ld  <= '0;
    end else begin
      r_ret <= r_ret + CNT_LEN'(WB_EN);
      r_ld  <= r_ld + CNT_LEN'(WB_EN && MEM_R_EN);
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage register file: consumes the MEM/WB pipeline register outputs, selects the writeback value and commits it to a 2^REG_FILE_ADDR_LEN x WORD_LEN register array. It serves the two ID-stage read ports, with same-cycle write-to-read bypass. It also keeps retirement and load-retirement counters for the pipeline testbench.

## Interface
Parameters:
- WORD_LEN, 32, data width (matches `WORD_LEN`)
- REG_FILE_ADDR_LEN, 5, register address width; array depth 2^REG_FILE_ADDR_LEN
- CNT_LEN, 32, width of each retirement counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk)
- WB_EN  in  1  writeback enable from MEM/WB
- MEM_R_EN  in  1  load flag from MEM/WB; selects memReadVal as writeback data
- ALURes  in  WORD_LEN  ALU result from MEM/WB
- memReadVal  in  WORD_LEN  load data from MEM/WB
- dest  in  REG_FILE_ADDR_LEN  destination register from MEM/WB
- src1  in  REG_FILE_ADDR_LEN  ID read address, port 1
- src2  in  REG_FILE_ADDR_LEN  ID read address, port 2
- clrCnt  in  1  synchronous clear of both counters
- WB_Value  out  WORD_LEN  selected writeback data (combinational)
- reg1  out  WORD_LEN  read data, port 1 (combinational)
- reg2  out  WORD_LEN  read data, port 2 (combinational)
- retireCnt  out  CNT_LEN  count of cycles with WB_EN=1
- loadCnt  out  CNT_LEN  count of cycles with WB_EN=1 and MEM_R_EN=1

## Operation
- WB_Value = MEM_R_EN ? memReadVal : ALURes, regardless of WB_EN.
- Write: at posedge clk, if WB_EN=1 and dest!=0, reg[dest] <= WB_Value. No write in any other case.
- Register 0 is hardwired to zero. It is never written, and reading it always returns 0.
- Read, evaluated independently for each port p with address srcp:
  - srcp==0 -> 0
  - else if WB_EN=1 and dest==srcp -> WB_Value (bypass of the write committing this cycle)
  - else -> reg[srcp]
- Both ports may address the same register. Each returns the identical value.
- Counters, updated at posedge clk:
  - clrCnt=1 -> both counters <= 0. Clear takes priority over a same-cycle increment.
  - Otherwise retireCnt += 1 when WB_EN=1. This includes writebacks to dest=0, which count as retired without writing.
  - loadCnt += 1 when WB_EN=1 and MEM_R_EN=1.
  - MEM_R_EN=1 with WB_EN=0 does not count.
  - Both counters are unsigned and wrap modulo 2^CNT_LEN (all-ones + 1 -> 0, no saturation).
- X on MEM_R_EN while WB_EN=0 must not corrupt the array.

## Timing
- Reset (rst=0, async): all array entries, retireCnt and loadCnt go to 0 immediately. reg1/reg2 read 0 for every address while in reset. WB_Value stays combinational from its inputs.
- While rst=0, the array and counters ignore clk, WB_EN and clrCnt.
- The first write can occur at the first posedge after rst rises.
- Reset asserted mid-operation discards the write of that cycle, even when the assertion lands in the same cycle as a WB_EN=1 edge.
- Write latency: the array updates at the posedge. Through bypass, the read ports already show the new value in the cycle before that edge, so there is zero visible latency to ID.
- reg1, reg2 and WB_Value are purely combinational. Combinational path: src/dest/WB_EN/MEM_R_EN/ALURes/memReadVal -> reg1/reg2.
- Counters are visible one cycle after the qualifying edge.

## Test plan
- Reset/zero: drive rst=0 mid-run after writing reg[5]=0x1234. Require reg1 (src1=5)=0 asynchronously, before the next edge. Require retireCnt=loadCnt=0.
- ALU write/read: WB_EN=1, MEM_R_EN=0, ALURes=0xDEADBEEF, dest=7, with src1=7 in the same cycle. Require reg1=0xDEADBEEF by bypass. Then WB_EN=0: reg1 still 0xDEADBEEF from the array.
- Load select: WB_EN=1, MEM_R_EN=1, memReadVal=0x00000042, ALURes=0xFFFFFFFF, dest=3. Require WB_Value=0x42, and reg[3]=0x42 after the edge. Require loadCnt and retireCnt each +1.
- R0 protection: WB_EN=1, dest=0, ALURes=0xAAAA5555, src1=src2=0. Require reg1=reg2=0 both before and after the edge. Require retireCnt +1 and loadCnt unchanged.
- Dual-port/same-register: src1=src2=9 with a WB_EN=1 write of 0x55 to 9. Require reg1=reg2=0x55. Then src1=9, src2=10 with no write: require 0x55 and the prior reg[10].
- Counter edge cases: set CNT_LEN=4 and issue 16 consecutive WB_EN=1 cycles. Require retireCnt to wrap to 0. Then assert clrCnt=1 together with WB_EN=1 and MEM_R_EN=1: require both counters to be 0 the next cycle.
